// File: rtl/lcd_cmd_arbiter_if.sv
// Requester-side bus of lcd_cmd_arbiter: two level requests, their
// {RS, DATA} words and the one-cycle acknowledge pulses.
interface lcd_cmd_arbiter_if;
  localparam int unsigned N_REQ  = 2;
  localparam int unsigned WORD_W = 9;

  logic [N_REQ-1:0]  iREQ;
  logic [WORD_W-1:0] iWORD0;
  logic [WORD_W-1:0] iWORD1;
  logic [N_REQ-1:0]  oACK;

  // Requesters drive requests and words, receive acknowledges.
  modport master (
    output iREQ, iWORD0, iWORD1,
    input  oACK
  );

  // Arbiter samples requests and words, drives acknowledges.
  modport slave (
    input  iREQ, iWORD0, iWORD1,
    output oACK
  );
endinterface

// File: rtl/lcd_cmd_arbiter.sv
// lcd_cmd_arbiter: owns the LCD_Controller write port. Replays the HD44780
// power-up sequence after reset, then grants the port to one of two
// requesters at a time, holding a settling delay after every command.
// Build option LCD_ARB_RR_EN: round-robin tie break (default: req0 wins).
module lcd_cmd_arbiter #(
  parameter int unsigned DLY_W      = 18,
  parameter int unsigned DLY_CYCLES = 32'h3FFFE
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  lcd_cmd_arbiter_if.slave     reqBus,
  output logic                 oINIT_DONE,
  output logic [7:0]           oLCD_DATA,
  output logic                 oLCD_RS,
  output logic                 oLCD_START,
  input  logic                 iLCD_DONE
);

  localparam int unsigned IDX_W    = 3;
  localparam int unsigned INIT_LEN = 5;
  localparam int unsigned WORD_W   = 9;

  typedef enum logic [2:0] {
    INIT_ISSUE,
    WAIT_DONE,
    DLY,
    NEXT,
    IDLE
  } state_t;

  state_t             state, stateNxt;
  logic [DLY_W-1:0]   dlyCnt, dlyCntNxt;
  logic [IDX_W-1:0]   initIdx, initIdxNxt;
  logic               initDoneNxt;
  logic [7:0]         lcdDataNxt;
  logic               lcdRsNxt;
  logic               lcdStartNxt;
  logic [1:0]         ackNxt;
  logic               winner;
  logic [WORD_W-1:0]  winWord;

  // HD44780 power-up words {RS, DATA}: function set, display on, clear,
  // entry mode, cursor home to line 1.
  function automatic logic [WORD_W-1:0] initRom(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    initRom = 9'h038;
      3'd1:    initRom = 9'h00C;
      3'd2:    initRom = 9'h001;
      3'd3:    initRom = 9'h006;
      3'd4:    initRom = 9'h080;
      default: initRom = 9'h000;
    endcase
  endfunction

`ifdef LCD_ARB_RR_EN
  logic rrPtr, rrPtrNxt;

  // Tie goes to the requester not granted last; single requests pass through.
  always_comb begin
    if (reqBus.iREQ == 2'b11) winner = ~rrPtr;
    else                      winner = ~reqBus.iREQ[0];
  end

  // Last-granted requester, moved only on a grant.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) rrPtr <= 1'b0;
    else         rrPtr <= rrPtrNxt;
  end

  // Pointer follows each grant.
  always_comb begin
    rrPtrNxt = rrPtr;
    if (state == IDLE && reqBus.iREQ != 2'b00) rrPtrNxt = winner;
  end
`else
  // Fixed priority: req0 wins whenever it is requesting.
  always_comb winner = ~reqBus.iREQ[0];
`endif

  assign winWord = winner ? reqBus.iWORD1 : reqBus.iWORD0;

  // State and registered outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state       <= INIT_ISSUE;
      dlyCnt      <= '0;
      initIdx     <= '0;
      oINIT_DONE  <= 1'b0;
      oLCD_DATA   <= 8'h00;
      oLCD_RS     <= 1'b0;
      oLCD_START  <= 1'b0;
      reqBus.oACK <= 2'b00;
    end else begin
      state       <= stateNxt;
      dlyCnt      <= dlyCntNxt;
      initIdx     <= initIdxNxt;
      oINIT_DONE  <= initDoneNxt;
      oLCD_DATA   <= lcdDataNxt;
      oLCD_RS     <= lcdRsNxt;
      oLCD_START  <= lcdStartNxt;
      reqBus.oACK <= ackNxt;
    end
  end

  // Next-state and next-output decode; the latched word only moves on issue.
  always_comb begin
    stateNxt    = state;
    dlyCntNxt   = dlyCnt;
    initIdxNxt  = initIdx;
    initDoneNxt = oINIT_DONE;
    lcdDataNxt  = oLCD_DATA;
    lcdRsNxt    = oLCD_RS;
    lcdStartNxt = oLCD_START;
    ackNxt      = 2'b00;
    case (state)
      INIT_ISSUE: begin
        {lcdRsNxt, lcdDataNxt} = initRom(initIdx);
        lcdStartNxt            = 1'b1;
        stateNxt               = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (iLCD_DONE) begin
          lcdStartNxt = 1'b0;
          dlyCntNxt   = '0;
          stateNxt    = DLY;
        end
      end
      DLY: begin
        if (dlyCnt == DLY_W'(DLY_CYCLES - 1)) begin
          dlyCntNxt = '0;
          stateNxt  = NEXT;
        end else begin
          dlyCntNxt = dlyCnt + DLY_W'(1);
        end
      end
      NEXT: begin
        if (!oINIT_DONE) begin
          initIdxNxt = initIdx + IDX_W'(1);
          if (initIdx == IDX_W'(INIT_LEN - 1)) begin
            initDoneNxt = 1'b1;
            stateNxt    = IDLE;
          end else begin
            stateNxt = INIT_ISSUE;
          end
        end else begin
          stateNxt = IDLE;
        end
      end
      IDLE: begin
        if (oINIT_DONE && reqBus.iREQ != 2'b00) begin
          {lcdRsNxt, lcdDataNxt} = winWord;
          lcdStartNxt            = 1'b1;
          ackNxt[winner]         = 1'b1;
          stateNxt               = WAIT_DONE;
        end
      end
      default: stateNxt = INIT_ISSUE;
    endcase
  end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Bench for lcd_cmd_arbiter: init replay, grant timing, tie breaking,
// word holding, spurious done, async reset and randomized traffic.
module tb_lcd_cmd_arbiter;
  localparam int unsigned DLY = 4;
  localparam int unsigned GAP = DLY + 2;

  logic       iCLK = 1'b0;
  logic       iRST_N;
  logic       iLCD_DONE;
  logic       oINIT_DONE;
  logic [7:0] oLCD_DATA;
  logic       oLCD_RS;
  logic       oLCD_START;

  lcd_cmd_arbiter_if bus();

  lcd_cmd_arbiter #(.DLY_W(18), .DLY_CYCLES(DLY)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .reqBus(bus),
    .oINIT_DONE(oINIT_DONE), .oLCD_DATA(oLCD_DATA), .oLCD_RS(oLCD_RS),
    .oLCD_START(oLCD_START), .iLCD_DONE(iLCD_DONE)
  );

  always #5 iCLK = ~iCLK;

  int nTests = 0;
  int nFail  = 0;

  logic [8:0] romExp [5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h080};

  bit         autoDone = 1'b1;
  bit         spurDone = 1'b0;
  int         startAge;
  logic [8:0] obsQ[$];
  int         gapQ[$];
  int         lowRun;
  logic       prevStart;
  logic [8:0] curWord;
  int         dataChanged;
  int         badAck;
  int         ackBeforeInit;
  int         totalAcks;
  logic [1:0] reqSampled;
  logic       lastWin;

  task automatic clearTrack();
    obsQ.delete(); gapQ.delete();
    lowRun = 0; prevStart = 1'b0; curWord = '0; startAge = 0;
    dataChanged = 0; badAck = 0; ackBeforeInit = 0; totalAcks = 0;
    lastWin = 1'b0;
  endtask

  // One clock: sample after the edge, record LCD writes, run controller model.
  task automatic step();
    reqSampled = bus.iREQ;
    @(posedge iCLK); #1;
    if (oLCD_START && !prevStart) begin
      obsQ.push_back({oLCD_RS, oLCD_DATA});
      gapQ.push_back(lowRun);
      curWord = {oLCD_RS, oLCD_DATA};
    end else if (oLCD_START && {oLCD_RS, oLCD_DATA} !== curWord) begin
      dataChanged++;
    end
    if (!oLCD_START) lowRun++; else lowRun = 0;
    if (bus.oACK == 2'b11) badAck++;
    if (bus.oACK != 2'b00 && !oINIT_DONE) ackBeforeInit++;
    if (bus.oACK[0]) totalAcks++;
    if (bus.oACK[1]) totalAcks++;
    prevStart = oLCD_START;
    if (oLCD_START) startAge++; else startAge = 0;
    iLCD_DONE = (autoDone && startAge == 3) || spurDone;
  endtask

  task automatic test_reset();
    iRST_N = 1'b0; iLCD_DONE = 1'b0;
    bus.iREQ = 2'b00; bus.iWORD0 = '0; bus.iWORD1 = '0;
    step(); step();
    nTests++; if (bus.oACK !== 2'b00) begin nFail++; $display("FAIL reset_ack: got %b expected 00", bus.oACK); end
    nTests++; if (oINIT_DONE !== 1'b0) begin nFail++; $display("FAIL reset_init_done: got %b expected 0", oINIT_DONE); end
    nTests++; if (oLCD_DATA !== 8'h00) begin nFail++; $display("FAIL reset_data: got %h expected 00", oLCD_DATA); end
    nTests++; if (oLCD_RS !== 1'b0) begin nFail++; $display("FAIL reset_rs: got %b expected 0", oLCD_RS); end
    nTests++; if (oLCD_START !== 1'b0) begin nFail++; $display("FAIL reset_start: got %b expected 0", oLCD_START); end
  endtask

  task automatic test_init();
    int cyc;
    int bad;
    clearTrack();
    iRST_N = 1'b1;
    bad = 0;
    for (cyc = 0; cyc < 400 && !oINIT_DONE; cyc++) begin
      step();
      if (oINIT_DONE && obsQ.size() < 5) bad++;
    end
    nTests++; if (!oINIT_DONE) begin nFail++; $display("FAIL init_timeout: init_done=%b after %0d cycles", oINIT_DONE, cyc); end
    nTests++; if (obsQ.size() != 5) begin nFail++; $display("FAIL init_count: got %0d writes expected 5", obsQ.size()); end
    for (int i = 0; i < 5 && i < obsQ.size(); i++) begin
      nTests++; if (obsQ[i] !== romExp[i]) begin nFail++; $display("FAIL init_word%0d: got %h expected %h", i, obsQ[i], romExp[i]); end
    end
    for (int i = 1; i < gapQ.size(); i++) begin
      nTests++; if (gapQ[i] != GAP) begin nFail++; $display("FAIL init_gap%0d: got %0d expected %0d", i, gapQ[i], GAP); end
    end
    nTests++; if (bad != 0) begin nFail++; $display("FAIL init_done_early: %0d samples expected 0", bad); end
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!oINIT_DONE || oLCD_START) bad++;
    end
    nTests++; if (bad != 0 || totalAcks != 0) begin nFail++; $display("FAIL init_idle: got %0d bad samples, %0d acks expected 0, 0", bad, totalAcks); end
  endtask

  task automatic test_req_during_init();
    int cyc;
    iRST_N = 1'b0;
    bus.iREQ = 2'b01; bus.iWORD0 = 9'h142; bus.iWORD1 = 9'h000;
    step();
    clearTrack();
    iRST_N = 1'b1;
    for (cyc = 0; cyc < 400 && !oINIT_DONE; cyc++) step();
    nTests++; if (!oINIT_DONE || totalAcks != 0) begin nFail++; $display("FAIL req_init_acks: init_done=%b acks=%0d expected 1, 0", oINIT_DONE, totalAcks); end
    step();
    nTests++; if (bus.oACK !== 2'b01 || oLCD_START !== 1'b1) begin nFail++; $display("FAIL req_init_grant: ack=%b start=%b expected 01 1", bus.oACK, oLCD_START); end
    nTests++; if ({oLCD_RS, oLCD_DATA} !== 9'h142) begin nFail++; $display("FAIL req_init_word: got %h expected 142", {oLCD_RS, oLCD_DATA}); end
    if (bus.oACK[0]) lastWin = 1'b0;
    bus.iREQ = 2'b00;
    step();
    nTests++; if (bus.oACK !== 2'b00) begin nFail++; $display("FAIL req_init_pulse: got %b expected 00", bus.oACK); end
    for (int i = 0; i < 30; i++) step();
    nTests++; if (totalAcks != 1) begin nFail++; $display("FAIL req_init_single: got %0d acks expected 1", totalAcks); end
  endtask

  task automatic test_tie();
    int  nAck;
    int  cyc;
    logic w;
    logic [1:0] expAck;
    logic [8:0] expWord;
    bus.iWORD0 = 9'h153; bus.iWORD1 = 9'h150; bus.iREQ = 2'b11;
    nAck = 0;
    for (cyc = 0; cyc < 200 && nAck < 4; cyc++) begin
      step();
      if (bus.oACK != 2'b00) begin
`ifdef LCD_ARB_RR_EN
        w = ~lastWin;
`else
        w = 1'b0;
`endif
        expAck  = w ? 2'b10 : 2'b01;
        expWord = w ? 9'h150 : 9'h153;
        nTests++; if (bus.oACK !== expAck) begin nFail++; $display("FAIL tie_ack%0d: got %b expected %b", nAck, bus.oACK, expAck); end
        nTests++; if ({oLCD_RS, oLCD_DATA} !== expWord) begin nFail++; $display("FAIL tie_word%0d: got %h expected %h", nAck, {oLCD_RS, oLCD_DATA}, expWord); end
        if (nAck > 0) begin
          nTests++; if (gapQ[gapQ.size()-1] != GAP) begin nFail++; $display("FAIL tie_gap%0d: got %0d expected %0d", nAck, gapQ[gapQ.size()-1], GAP); end
        end
        lastWin = w;
        nAck++;
      end
    end
    bus.iREQ = 2'b00;
    nTests++; if (nAck != 4 || badAck != 0) begin nFail++; $display("FAIL tie_count: got %0d acks, %0d double acks expected 4, 0", nAck, badAck); end
    for (int i = 0; i < 20; i++) step();
  endtask

  task automatic test_word_hold();
    int cyc;
    int bad;
    autoDone = 1'b0;
    bus.iWORD0 = 9'h161; bus.iREQ = 2'b01;
    for (cyc = 0; cyc < 50 && bus.oACK == 2'b00; cyc++) step();
    nTests++; if (bus.oACK !== 2'b01 || oLCD_DATA !== 8'h61) begin nFail++; $display("FAIL hold_grant: ack=%b data=%h expected 01 61", bus.oACK, oLCD_DATA); end
    lastWin = 1'b0;
    bus.iWORD0 = 9'h173;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (oLCD_START !== 1'b1 || oLCD_DATA !== 8'h61 || bus.oACK !== 2'b00) bad++;
    end
    nTests++; if (bad != 0) begin nFail++; $display("FAIL hold_stable: got %0d bad samples expected 0", bad); end
    spurDone = 1'b1;
    step();
    spurDone = 1'b0;
    nTests++; if (oLCD_START !== 1'b1 || oLCD_DATA !== 8'h61) begin nFail++; $display("FAIL hold_pre_done: start=%b data=%h expected 1 61", oLCD_START, oLCD_DATA); end
    step();
    nTests++; if (oLCD_START !== 1'b0) begin nFail++; $display("FAIL hold_drop: got %b expected 0", oLCD_START); end
    autoDone = 1'b1;
    for (cyc = 0; cyc < 50 && bus.oACK == 2'b00; cyc++) step();
    nTests++; if (bus.oACK !== 2'b01 || {oLCD_RS, oLCD_DATA} !== 9'h173 || gapQ[gapQ.size()-1] != GAP) begin
      nFail++; $display("FAIL hold_next: ack=%b word=%h gap=%0d expected 01 173 %0d", bus.oACK, {oLCD_RS, oLCD_DATA}, gapQ[gapQ.size()-1], GAP);
    end
    bus.iREQ = 2'b00;
    for (int i = 0; i < 20; i++) step();
  endtask

  task automatic test_spurious();
    int cyc;
    int bad;
    int acks0;
    acks0 = totalAcks;
    spurDone = 1'b1; step(); spurDone = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (oLCD_START !== 1'b0) bad++;
    end
    nTests++; if (bad != 0 || totalAcks != acks0) begin nFail++; $display("FAIL spur_idle: %0d bad samples, %0d new acks expected 0, 0", bad, totalAcks - acks0); end
    bus.iWORD1 = 9'h0AA; bus.iREQ = 2'b10;
    step();
    nTests++; if (bus.oACK !== 2'b10 || {oLCD_RS, oLCD_DATA} !== 9'h0AA) begin nFail++; $display("FAIL spur_latency: ack=%b word=%h expected 10 0aa", bus.oACK, {oLCD_RS, oLCD_DATA}); end
    lastWin = 1'b1;
    bus.iREQ = 2'b01; bus.iWORD0 = 9'h1BB;
    for (cyc = 0; cyc < 50 && oLCD_START; cyc++) step();
    step();
    spurDone = 1'b1; step(); spurDone = 1'b0;
    for (cyc = 0; cyc < 50 && bus.oACK == 2'b00; cyc++) step();
    nTests++; if (bus.oACK !== 2'b01 || {oLCD_RS, oLCD_DATA} !== 9'h1BB || gapQ[gapQ.size()-1] != GAP) begin
      nFail++; $display("FAIL spur_dly: ack=%b word=%h gap=%0d expected 01 1bb %0d", bus.oACK, {oLCD_RS, oLCD_DATA}, gapQ[gapQ.size()-1], GAP);
    end
    lastWin = 1'b0;
    bus.iREQ = 2'b00;
    for (int i = 0; i < 20; i++) step();
  endtask

  task automatic test_random();
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    int gen;
    int acked;
    bit fin;
    logic w;
    logic [1:0] expAck;
    logic [8:0] expWord;
    gen = 0; acked = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      if (gen < 24 && $urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 1) == 1) q0.push_back(9'($urandom));
        else                           q1.push_back(9'($urandom));
        gen++;
      end
      bus.iREQ   = {q1.size() != 0, q0.size() != 0};
      bus.iWORD0 = (q0.size() != 0) ? q0[0] : 9'($urandom);
      bus.iWORD1 = (q1.size() != 0) ? q1[0] : 9'($urandom);
      step();
      if (bus.oACK != 2'b00) begin
`ifdef LCD_ARB_RR_EN
        if (reqSampled == 2'b11) w = ~lastWin; else w = reqSampled[1];
`else
        if (reqSampled == 2'b11) w = 1'b0; else w = reqSampled[1];
`endif
        expAck = (reqSampled == 2'b00) ? 2'b00 : (w ? 2'b10 : 2'b01);
        nTests++;
        if (bus.oACK !== expAck) begin
          nFail++; $display("FAIL rand_ack%0d: got %b expected %b", acked, bus.oACK, expAck);
        end else begin
          expWord = w ? q1[0] : q0[0];
          nTests++; if ({oLCD_RS, oLCD_DATA} !== expWord) begin nFail++; $display("FAIL rand_word%0d: got %h expected %h", acked, {oLCD_RS, oLCD_DATA}, expWord); end
          if (w) void'(q1.pop_front()); else void'(q0.pop_front());
          lastWin = w;
          acked++;
        end
      end
      if (gen == 24 && q0.size() == 0 && q1.size() == 0) fin = 1'b1;
    end
    bus.iREQ = 2'b00;
    nTests++; if (acked != 24) begin nFail++; $display("FAIL rand_drain: got %0d grants expected 24", acked); end
    nTests++; if (badAck != 0 || dataChanged != 0 || ackBeforeInit != 0) begin
      nFail++; $display("FAIL rand_protocol: double=%0d changed=%0d early=%0d expected 0 0 0", badAck, dataChanged, ackBeforeInit);
    end
    for (int i = 0; i < 20; i++) step();
  endtask

  task automatic test_reset_mid();
    int cyc;
    int bad;
    bus.iWORD0 = 9'h1CC; bus.iREQ = 2'b01;
    for (cyc = 0; cyc < 50 && bus.oACK == 2'b00; cyc++) step();
    bus.iREQ = 2'b00;
    for (cyc = 0; cyc < 50 && oLCD_START; cyc++) step();
    step();
    @(negedge iCLK);
    iRST_N = 1'b0;
    #1;
    nTests++; if ({oINIT_DONE, oLCD_RS, oLCD_DATA, oLCD_START, bus.oACK} !== 13'h0) begin
      nFail++; $display("FAIL rstmid_outputs: done=%b rs=%b data=%h start=%b ack=%b expected all 0", oINIT_DONE, oLCD_RS, oLCD_DATA, oLCD_START, bus.oACK);
    end
    step(); step();
    clearTrack();
    iRST_N = 1'b1;
    bad = 0;
    for (cyc = 0; cyc < 400 && !oINIT_DONE; cyc++) begin
      step();
      if (oINIT_DONE && obsQ.size() < 5) bad++;
    end
    nTests++; if (obsQ.size() != 5 || bad != 0) begin nFail++; $display("FAIL rstmid_count: writes=%0d early=%0d expected 5 0", obsQ.size(), bad); end
    for (int i = 0; i < 5 && i < obsQ.size(); i++) begin
      nTests++; if (obsQ[i] !== romExp[i]) begin nFail++; $display("FAIL rstmid_word%0d: got %h expected %h", i, obsQ[i], romExp[i]); end
    end
  endtask

  initial begin
    clearTrack();
    test_reset();
    test_init();
    test_req_during_init();
    test_tie();
    test_word_hold();
    test_spurious();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/lcd_cmd_arbiter.md
Name: lcd_cmd_arbiter

Overview:
Owns the single LCD_Controller write port and sequences every character/command write to the 16x2 HD44780 LCD.
After reset it autonomously issues the LCD power-up command sequence. It then shares the port between two requesters: req0 is the mode/status text writer and req1 is the note/pitch display writer.
Each requester presents one 9-bit word {RS, DATA[7:0]} per request. The arbiter drives the controller start/done handshake and enforces the inter-command settling delay.

Parameters:
DLY_CYCLES, 18'h3FFFE, idle cycles inserted after each oLCD_START/iLCD_DONE completion before the next grant
DLY_W, 18, width of the delay counter; must satisfy DLY_CYCLES < 2^DLY_W

Ports:
iCLK  in  1  system clock
iRST_N  in  1  asynchronous active-low reset
iREQ  in  2  per-requester request; level, held until acked
iWORD0  in  9  requester 0 word {RS, DATA}; valid while iREQ[0]
iWORD1  in  9  requester 1 word {RS, DATA}; valid while iREQ[1]
oACK  out  2  one-cycle pulse; word of that requester accepted
oINIT_DONE  out  1  high once the init sequence completes; sticky until reset
oLCD_DATA  out  8  to LCD_Controller iDATA
oLCD_RS  out  1  to LCD_Controller iRS
oLCD_START  out  1  to LCD_Controller iStart
iLCD_DONE  in  1  from LCD_Controller oDone

Behaviour:
- Interface: reset iRST_N, asynchronous, active-low; clock iCLK. All outputs are registered.
- Reset values: oACK=0, oINIT_DONE=0, oLCD_DATA=0, oLCD_RS=0, oLCD_START=0, delay counter=0, init index=0, rr pointer=0, state=INIT_ISSUE.
- Init ROM is fixed, index 0..4: 9'h038, 9'h00C, 9'h001, 9'h006, 9'h080.
- States:
  INIT_ISSUE: load ROM[idx] into oLCD_RS/oLCD_DATA, set oLCD_START=1, go to WAIT_DONE.
  WAIT_DONE: hold oLCD_START=1 and data stable. On iLCD_DONE=1, set oLCD_START=0, clear the counter, go to DLY.
  DLY: increment the counter; when counter==DLY_CYCLES-1, clear it and go to NEXT.
  NEXT: if init is not complete, increment idx. If idx becomes 5, set oINIT_DONE=1 and go to IDLE; otherwise go to INIT_ISSUE. If init is already complete, go to IDLE.
  IDLE: if iREQ != 0, select the winner, latch its word into oLCD_RS/oLCD_DATA, set oLCD_START=1, pulse oACK[winner] for exactly one cycle, and go to WAIT_DONE.
- Grant latency: iREQ is sampled at edge N while in IDLE. oACK and oLCD_START are high after edge N.
- Minimum command period: 1 grant + done wait (>=1) + DLY_CYCLES + 1 NEXT cycle.
- Requester rule: in the cycle after seeing oACK, the requester either deasserts iREQ or presents its next word. Requests are not sampled outside IDLE, so a held iREQ is never double-acked.
- During init (oINIT_DONE=0), requests are ignored and never acked.
- Simultaneous requests: winner chosen per Optional Feature. Exactly one oACK bit is high in any cycle.
- iLCD_DONE outside WAIT_DONE is ignored.
- Async reset mid-operation: all state clears immediately and oLCD_START drops. The init sequence re-runs from idx 0 after reset release.
- The latched word does not change while oLCD_START=1, even if iWORDx changes.

Optional Feature:
LCD_ARB_RR_EN
- Defined: round-robin arbitration. A 1-bit pointer records the last granted requester; on a tie the other requester wins.
- Pointer updates only on grant. Reset value 0, so the first tie goes to req1.
- Undefined: fixed priority, req0 always wins a tie. No pointer register.
- Single requests are granted identically in both builds.

Test Plan:
All scenarios use DLY_CYCLES=4 and a controller model that asserts iLCD_DONE 3 cycles after iLCD_START rises.
1. Reset release, no requests -> oLCD_START pulses 5 times with {RS,DATA} = 038, 00C, 001, 006, 080 in order; gaps obey DLY; oINIT_DONE rises after the 5th command and stays 1.
2. iREQ=01 held from reset, iWORD0=9'h142 -> no oACK before oINIT_DONE. oACK=01 for one cycle on the first IDLE edge; oLCD_RS=1, oLCD_DATA=8'h42; exactly one grant.
3. After init, iREQ=11 held, iWORD0=9'h153, iWORD1=9'h150 for 4 grants -> fixed build: 4 acks all to req0; LCD_ARB_RR_EN build: acks alternate 1,0,1,0 and data alternates 50,53.
4. During WAIT_DONE, change iWORD0 from 9'h161 to 9'h173 -> oLCD_DATA stays 8'h61 until iLCD_DONE; oLCD_START drops the cycle after iLCD_DONE.
5. Assert iRST_N=0 mid-DLY of a user write -> outputs return to reset values in the same cycle; after release, the init ROM replays from 9'h038 and oINIT_DONE=0 until it completes.
6. Spurious iLCD_DONE pulse in IDLE and in DLY -> no state change, no oACK, and the delay count is unaffected.
